// File: rtl/presort_pkg.sv
// Shared types and sizing helpers for the presort chunk serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package presort_pkg;

    // Default geometry: 16 records per beat, 8 records per sorted chunk.
    localparam int DEF_AXI_DATA_WIDTH    = 512;
    localparam int DEF_DATA_WIDTH        = 32;
    localparam int DEF_KEY_WIDTH         = 32;
    localparam int DEF_INIT_SORTED_CHUNK = 8;

    // The only state is whether the holding register owns a beat.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Records per presorted beat.
    function automatic int calc_full(input int axi_w, input int data_w);
        return axi_w / data_w;
    endfunction

    // Sorted chunks per presorted beat.
    function automatic int calc_chunk_num(input int full, input int chunk);
        return full / chunk;
    endfunction

    // Width of a record count that must reach FULL inclusive.
    function automatic int calc_cw(input int full);
        return $clog2(full + 1);
    endfunction

    // Valid records in chunk k of a beat holding `count` valid records.
    function automatic int chunk_cnt(input int count, input int k, input int chunk);
        int r;
        r = count - k * chunk;
        if (r < 0)     r = 0;
        if (r > chunk) r = chunk;
        return r;
    endfunction

    // Chunks to emit for a beat; an empty beat still emits one terminator.
    function automatic int chunk_num(input int count, input int chunk);
        if (count == 0) return 1;
        return (count + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/presort_chunk_serializer.sv
// Splits each presorted beat into sorted chunks, one chunk per cycle, dropping padding-only chunks.
// Latency: beat accepted at cycle N presents chunk 0 at N+1; full beat drains in CHUNK_NUM cycles.
// Backpressure: m_ready stalls the drain with outputs held; s_ready only rises on the final handshake.
module presort_chunk_serializer
    import presort_pkg::*;
#(
    parameter int AXI_DATA_WIDTH    = DEF_AXI_DATA_WIDTH,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int KEY_WIDTH         = DEF_KEY_WIDTH,
    parameter int INIT_SORTED_CHUNK = DEF_INIT_SORTED_CHUNK
) (
    input  logic                                              aclk,
    input  logic                                              aresetn,
    input  logic                                              s_valid,
    output logic                                              s_ready,
    input  logic [AXI_DATA_WIDTH-1:0]                         s_data,
    input  logic [$clog2(AXI_DATA_WIDTH/DATA_WIDTH+1)-1:0]    s_count,
    input  logic                                              s_last,
    output logic                                              m_valid,
    input  logic                                              m_ready,
    output logic [INIT_SORTED_CHUNK*DATA_WIDTH-1:0]           m_data,
    output logic [$clog2(INIT_SORTED_CHUNK+1)-1:0]            m_count,
    output logic                                              m_last
);

    localparam int FULL       = calc_full(AXI_DATA_WIDTH, DATA_WIDTH);
    localparam int CHUNK_NUM  = calc_chunk_num(FULL, INIT_SORTED_CHUNK);
    localparam int CW         = calc_cw(FULL);
    localparam int MCW        = $clog2(INIT_SORTED_CHUNK + 1);
    localparam int CHUNK_BITS = INIT_SORTED_CHUNK * DATA_WIDTH;
    localparam int IW         = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1;
    localparam int SW         = (AXI_DATA_WIDTH > 1) ? $clog2(AXI_DATA_WIDTH) : 1;

    // Geometry sanity: keys live inside a record, chunks tile a beat exactly.
    if (KEY_WIDTH > DATA_WIDTH) begin : g_bad_key
        $error("KEY_WIDTH must not exceed DATA_WIDTH");
    end
    if ((INIT_SORTED_CHUNK & (INIT_SORTED_CHUNK - 1)) != 0) begin : g_bad_pow2
        $error("INIT_SORTED_CHUNK must be a power of two");
    end
    if ((FULL % INIT_SORTED_CHUNK) != 0) begin : g_bad_div
        $error("INIT_SORTED_CHUNK must divide AXI_DATA_WIDTH/DATA_WIDTH");
    end

    state_e                  state_q, state_d;
    logic [AXI_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [CW-1:0]           hold_count_q, hold_count_d;
    logic                    hold_last_q, hold_last_d;
    logic [IW-1:0]           idx_q, idx_d;

    logic                    hold_full;
    logic [CW-1:0]           cnt_sat;
    logic                    last_chunk;
    logic                    load;
    logic [SW-1:0]           sel_base;

    // Handshake decode and chunk mux; m_* see only registers and idx, never s_*.
    always_comb begin
        hold_full  = (state_q == ST_DRAIN);
        cnt_sat    = (s_count > CW'(FULL)) ? CW'(FULL) : s_count;
        last_chunk = hold_full &&
                     (int'(idx_q) == chunk_num(int'(hold_count_q), INIT_SORTED_CHUNK) - 1);
        s_ready    = aresetn && (!hold_full || (m_ready && last_chunk));
        // An empty non-final beat carries nothing; it is swallowed without output.
        load       = s_valid && s_ready && ((cnt_sat != '0) || s_last);
        sel_base   = SW'(int'(idx_q) * CHUNK_BITS);
        m_valid    = hold_full;
        m_data     = hold_full ? hold_data_q[sel_base +: CHUNK_BITS] : '0;
        m_count    = hold_full ?
                     MCW'(chunk_cnt(int'(hold_count_q), int'(idx_q), INIT_SORTED_CHUNK)) : '0;
        m_last     = hold_full && hold_last_q && last_chunk;
    end

    // Next state: advance idx on handshake, retire on last chunk, reload on accepted beat.
    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_count_d = hold_count_q;
        hold_last_d  = hold_last_q;
        idx_d        = idx_q;
        if (hold_full && m_ready) begin
            if (last_chunk) begin
                state_d = ST_EMPTY;
                idx_d   = '0;
            end else begin
                idx_d   = idx_q + IW'(1);
            end
        end
        if (load) begin
            state_d      = ST_DRAIN;
            hold_data_d  = s_data;
            hold_count_d = cnt_sat;
            hold_last_d  = s_last;
            idx_d        = '0;
        end
    end

    // Holding register and drain FSM state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_EMPTY;
            hold_data_q  <= '0;
            hold_count_q <= '0;
            hold_last_q  <= 1'b0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_count_q <= hold_count_d;
            hold_last_q  <= hold_last_d;
            idx_q        <= idx_d;
        end
    end

    // An empty beat is only meaningful as a run terminator.
    a_empty_needs_last : assert property (@(posedge aclk) disable iff (!aresetn)
        !(s_valid && s_ready && (s_count == '0) && !s_last));

endmodule

// File: tb/tb_presort_chunk_serializer.sv
// Directed bench for presort_chunk_serializer (16 records/beat, 8 records/chunk).
// Inputs change on the falling edge; outputs are sampled 1ns later.
// Each scenario task carries its own inline comparisons.
module tb_presort_chunk_serializer;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         s_valid;
    logic         s_ready;
    logic [511:0] s_data;
    logic [4:0]   s_count;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [255:0] m_data;
    logic [3:0]   m_count;
    logic         m_last;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    presort_chunk_serializer dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_count (s_count),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count),
        .m_last  (m_last)
    );

    // Records below cnt are base+i; the rest are all-ones padding.
    function automatic logic [511:0] mk_beat(input int cnt, input logic [31:0] base);
        logic [511:0] b;
        for (int i = 0; i < 16; i++)
            b[i*32 +: 32] = (i < cnt) ? base + 32'(i) : 32'hFFFF_FFFF;
        return b;
    endfunction

    function automatic logic [255:0] chunk_of(input logic [511:0] b, input int k);
        return b[k*256 +: 256];
    endfunction

    task automatic drive_beat(input logic v, input int cnt, input logic last, input logic [31:0] base);
        s_valid = v;
        s_count = 5'(cnt);
        s_last  = last;
        s_data  = mk_beat(cnt, base);
    endtask

    task automatic test_reset;
        aresetn = 1'b0; m_ready = 1'b0;
        drive_beat(1'b0, 0, 1'b0, 32'h0);
        repeat (2) @(negedge aclk);
        #1;
        checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
        checks++; if (m_data !== '0)     begin errors++; $display("FAIL rst_m_data got %h exp 0", m_data); end
        checks++; if (m_count !== 4'd0)  begin errors++; $display("FAIL rst_m_count got %0d exp 0", m_count); end
        checks++; if (m_last !== 1'b0)   begin errors++; $display("FAIL rst_m_last got %b exp 0", m_last); end
        checks++; if (s_ready !== 1'b0)  begin errors++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1)  begin errors++; $display("FAIL post_rst_s_ready got %b exp 1", s_ready); end
    endtask

    task automatic test_full_beat;
        logic [511:0] b;
        b = mk_beat(16, 32'h1000_0000);
        @(negedge aclk);
        drive_beat(1'b1, 16, 1'b1, 32'h1000_0000); m_ready = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL full_pre_valid got %b exp 0", m_valid); end
        @(negedge aclk);
        s_valid = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL full_c0_valid got %b exp 1", m_valid); end
        checks++; if (m_data !== chunk_of(b, 0)) begin errors++; $display("FAIL full_c0_data got %h exp %h", m_data, chunk_of(b, 0)); end
        checks++; if (m_count !== 4'd8) begin errors++; $display("FAIL full_c0_count got %0d exp 8", m_count); end
        checks++; if (m_last !== 1'b0)  begin errors++; $display("FAIL full_c0_last got %b exp 0", m_last); end
        @(negedge aclk); #1;
        checks++; if (m_data !== chunk_of(b, 1)) begin errors++; $display("FAIL full_c1_data got %h exp %h", m_data, chunk_of(b, 1)); end
        checks++; if (m_count !== 4'd8) begin errors++; $display("FAIL full_c1_count got %0d exp 8", m_count); end
        checks++; if (m_last !== 1'b1)  begin errors++; $display("FAIL full_c1_last got %b exp 1", m_last); end
        @(negedge aclk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL full_done_valid got %b exp 0", m_valid); end
    endtask

    task automatic test_partial_11;
        logic [511:0] b;
        b = mk_beat(11, 32'h2000_0000);
        @(negedge aclk);
        drive_beat(1'b1, 11, 1'b1, 32'h2000_0000); m_ready = 1'b1;
        @(negedge aclk);
        s_valid = 1'b0;
        #1;
        checks++; if (m_count !== 4'd8) begin errors++; $display("FAIL p11_c0_count got %0d exp 8", m_count); end
        checks++; if (m_last !== 1'b0)  begin errors++; $display("FAIL p11_c0_last got %b exp 0", m_last); end
        @(negedge aclk); #1;
        checks++; if (m_count !== 4'd3) begin errors++; $display("FAIL p11_c1_count got %0d exp 3", m_count); end
        checks++; if (m_last !== 1'b1)  begin errors++; $display("FAIL p11_c1_last got %b exp 1", m_last); end
        checks++; if (m_data[255:96] !== {5{32'hFFFF_FFFF}}) begin errors++; $display("FAIL p11_c1_pad got %h exp all ones", m_data[255:96]); end
        checks++; if (m_data[95:0] !== {32'h2000_000A, 32'h2000_0009, 32'h2000_0008}) begin errors++; $display("FAIL p11_c1_recs got %h", m_data[95:0]); end
        @(negedge aclk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL p11_done_valid got %b exp 0", m_valid); end
    endtask

    task automatic test_partial_5;
        @(negedge aclk);
        drive_beat(1'b1, 5, 1'b1, 32'h3000_0000); m_ready = 1'b1;
        @(negedge aclk);
        s_valid = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL p5_valid got %b exp 1", m_valid); end
        checks++; if (m_count !== 4'd5) begin errors++; $display("FAIL p5_count got %0d exp 5", m_count); end
        checks++; if (m_last !== 1'b1)  begin errors++; $display("FAIL p5_last got %b exp 1", m_last); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL p5_s_ready got %b exp 1", s_ready); end
        @(negedge aclk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL p5_no_chunk1 got %b exp 0", m_valid); end
    endtask

    task automatic test_backpressure;
        logic [511:0] a;
        logic [511:0] b;
        a = mk_beat(16, 32'h4000_0000);
        b = mk_beat(5, 32'h5000_0000);
        @(negedge aclk);
        drive_beat(1'b1, 16, 1'b0, 32'h4000_0000); m_ready = 1'b1;
        @(negedge aclk);
        drive_beat(1'b1, 5, 1'b1, 32'h5000_0000); m_ready = 1'b1;
        #1;
        checks++; if (m_data !== chunk_of(a, 0)) begin errors++; $display("FAIL bp_c0_data got %h exp %h", m_data, chunk_of(a, 0)); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_c0_s_ready got %b exp 0", s_ready); end
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            m_ready = 1'b0;
            #1;
            checks++; if (m_data !== chunk_of(a, 1)) begin errors++; $display("FAIL bp_stall%0d_data got %h exp %h", i, m_data, chunk_of(a, 1)); end
            checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL bp_stall%0d_last got %b exp 0", i, m_last); end
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d_s_ready got %b exp 0", i, s_ready); end
        end
        @(negedge aclk);
        m_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_final_s_ready got %b exp 1", s_ready); end
        checks++; if (m_data !== chunk_of(a, 1)) begin errors++; $display("FAIL bp_final_data got %h exp %h", m_data, chunk_of(a, 1)); end
        @(negedge aclk);
        s_valid = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %b exp 1", m_valid); end
        checks++; if (m_data !== chunk_of(b, 0)) begin errors++; $display("FAIL bp_next_data got %h exp %h", m_data, chunk_of(b, 0)); end
        checks++; if (m_count !== 4'd5) begin errors++; $display("FAIL bp_next_count got %0d exp 5", m_count); end
        @(negedge aclk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_valid got %b exp 0", m_valid); end
    endtask

    task automatic test_empty_term;
        @(negedge aclk);
        drive_beat(1'b1, 0, 1'b1, 32'h0); m_ready = 1'b1;
        @(negedge aclk);
        s_valid = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL empty_valid got %b exp 1", m_valid); end
        checks++; if (m_count !== 4'd0) begin errors++; $display("FAIL empty_count got %0d exp 0", m_count); end
        checks++; if (m_last !== 1'b1)  begin errors++; $display("FAIL empty_last got %b exp 1", m_last); end
        @(negedge aclk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL empty_done_valid got %b exp 0", m_valid); end
    endtask

    task automatic test_saturate;
        @(negedge aclk);
        drive_beat(1'b1, 16, 1'b1, 32'h6000_0000); s_count = 5'd20; m_ready = 1'b1;
        @(negedge aclk);
        s_valid = 1'b0;
        #1;
        checks++; if (m_count !== 4'd8) begin errors++; $display("FAIL sat_c0_count got %0d exp 8", m_count); end
        @(negedge aclk); #1;
        checks++; if (m_count !== 4'd8) begin errors++; $display("FAIL sat_c1_count got %0d exp 8", m_count); end
        checks++; if (m_last !== 1'b1)  begin errors++; $display("FAIL sat_c1_last got %b exp 1", m_last); end
        @(negedge aclk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL sat_done_valid got %b exp 0", m_valid); end
    endtask

    task automatic test_reset_mid_drain;
        logic [511:0] c;
        c = mk_beat(16, 32'h7000_0000);
        @(negedge aclk);
        drive_beat(1'b1, 16, 1'b1, 32'h6600_0000); m_ready = 1'b0;
        @(negedge aclk);
        s_valid = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", m_valid); end
        aresetn = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", m_valid); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_ready got %b exp 0", s_ready); end
        @(negedge aclk);
        aresetn = 1'b1;
        drive_beat(1'b1, 16, 1'b1, 32'h7000_0000); m_ready = 1'b1;
        @(negedge aclk);
        s_valid = 1'b0;
        #1;
        checks++; if (m_data !== chunk_of(c, 0)) begin errors++; $display("FAIL mid_restart_data got %h exp %h", m_data, chunk_of(c, 0)); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL mid_restart_last got %b exp 0", m_last); end
        @(negedge aclk); #1;
        checks++; if (m_data !== chunk_of(c, 1)) begin errors++; $display("FAIL mid_restart_c1 got %h exp %h", m_data, chunk_of(c, 1)); end
        @(negedge aclk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_done_valid got %b exp 0", m_valid); end
    endtask

    initial begin
        test_reset;
        test_full_beat;
        test_partial_11;
        test_partial_5;
        test_backpressure;
        test_empty_term;
        test_saturate;
        test_reset_mid_drain;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
